alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised integer ALU for the O-O integer issue slots: add/logic/compare/shNadd/pc-relative ops, optional bitfield ops.
//  Configurable latency (LAT stages); stalls under result-bus backpressure and flushes killed ops per hart mid-flight.
//  Sits between the issue queue and the writeback/commit bus.
// PARAMETERS
//  RV        64   datapath width, 32 or 64 (addw/.w forms exist only when 64)
//  VA_SZ     48   virtual address bits; pc is [VA_SZ-1:1]
//  LAT       2    issue-to-result latency in cycles, 1..4
//  NHART     1    harts sharing the unit
//  LNHART    0    log2(NHART); 0 when NHART==1
//  NCOMMIT   32   commit entries per hart
//  LNCOMMIT  5    log2(NCOMMIT)
//  CNTRL_SIZE 7   control width
// PORTS
//  clk          in   1                   clock
//  reset_n      in   1                   async, active-low reset
//  enable       in   1                   issue valid
//  control      in   CNTRL_SIZE          [5]+[2:0]=op, [4]=addw, [3]=inv/unsigned
//  rd           in   LNCOMMIT            destination commit tag
//  makes_rd     in   1                   op writes rd
//  needs_rs2    in   1                   1: r2 operand, 0: sign-extended immed
//  r1, r2       in   RV                  source operands
//  pc           in   VA_SZ-1             instruction pc (bit 0 implicit 0)
//  immed        in   32                  immediate; [1:0] selects clz/ctz/cpop for op 13
//  hart         in   max(LNHART,1)       issuing hart
//  rv32         in   1                   hart in RV32 mode
//  commit_kill  in   NHART*NCOMMIT       kill bit per {hart,tag}
//  res_stall    in   1                   writeback bus refuses result this cycle
//  busy         out  1                   unit cannot accept issue this cycle
//  res_valid    out  1                   result/res_rd valid
//  result       out  RV                  result
//  res_rd       out  LNCOMMIT            result tag
//  res_makes_rd out  NHART               one-hot hart write enable
// BEHAVIOUR
//  - Reset: every stage valid=0; res_valid, res_makes_rd, busy = 0; result, res_rd = 0. Reset mid-op discards all in-flight ops.
//  - Issue accepted when enable & !busy; all inputs sampled same cycle. Result appears exactly LAT cycles later absent stalls.
//  - Ops: 0 add, 1 xor, 2 and, 3 or, 4 slt, 5 sltu, 8 add with r1=pc, 9/a/b add r1<<1/2/3, c add.uw (r1 zero-extended),
//    e zext.w-add; inv=1 inverts operand2 and injects carry (sub). addw (RV==64, op[3]=0) sign-extends bit 31 of sum.
//    addw with shNadd uses r1[31:0] zero-extended before shift. slt/sltu return 0/1 zero-extended to RV.
//  - Compute in stage 0; stages 1..LAT-1 are pure delay registers (retiming permitted, latency fixed).
//  - Stall: res_stall & res_valid freezes every stage; busy = res_stall & res_valid & stage0 occupied.
//    res_stall with res_valid=0 is ignored (bubbles collapse: pipeline keeps advancing).
//  - Issue while busy is dropped; simulation assertion fires.
//  - Kill: any stage (incl. issue cycle and final/stalled stage) whose commit_kill[hart*NCOMMIT+rd] is 1 clears valid
//    the next edge; killed op never raises res_valid. Kill and stall same cycle: kill wins.
//  - res_makes_rd = res_valid & makes_rd ? onehot(hart) : 0. res_valid=1 with makes_rd=0 is legal (no write).
//  - Back-to-back issue every cycle sustains 1 result/cycle; tag order preserved (in-order pipe).
//  - Unused/undefined op codes: result 0, res_valid still asserted.
// CONFIGURATION
//  ALU_ZBB_EN defined: op 6 min/minu, 7 max/maxu (control[3]=unsigned), op 13 by immed[1:0]: 00 clz, 01 ctz, 10 cpop;
//    with addw|rv32 counts use r1[31:0] only (clzw of 0 = 32, clz of 0 = 64).
//  ALU_ZBB_EN undefined: ops 6, 7, 13 decode as undefined (result 0); no counting logic instantiated.
// TESTING
//  1 LAT=2: issue add r1=5 r2=7 rd=3 at t -> res_valid, result=12, res_rd=3 at t+2 only.
//  2 sub (inv=1) r1=0 r2=1 -> 0xFFFF_FFFF_FFFF_FFFF; addw r1=0x7FFF_FFFF r2=1 -> 0xFFFF_FFFF_8000_0000.
//  3 4 back-to-back issues, res_stall=1 for 3 cycles from first res_valid -> busy=1, results held, all 4 emerge in order.
//  4 issue rd=9 hart 0, pulse commit_kill[9] one cycle later -> no res_valid for rd=9; neighbours unaffected.
//  5 ALU_ZBB_EN: clz r1=1 -> 63; clzw (addw) r1=1 -> 31; cpop r1=0xF0F0 -> 8; minu 3,0xFFFF.. -> 3; undefined -> 0.
//  6 reset_n low while 2 ops in flight -> outputs 0 immediately; after release no stale res_valid.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined integer ALU: the result appears LAT cycles after issue; it stalls on result-bus backpressure and drops killed ops.
// Optional feature: define ALU_ZBB_EN to add min/max and clz/ctz/cpop.
module alu_pipe #(
  parameter int RV         = 64,
  parameter int VA_SZ      = 48,
  parameter int LAT        = 2,
  parameter int NHART      = 1,
  parameter int LNHART     = 0,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int CNTRL_SIZE = 7
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                enable,
  input  logic [CNTRL_SIZE-1:0]               control,
  input  logic [LNCOMMIT-1:0]                 rd,
  input  logic                                makes_rd,
  input  logic                                needs_rs2,
  input  logic [RV-1:0]                       r1,
  input  logic [RV-1:0]                       r2,
  input  logic [VA_SZ-1:1]                    pc,
  input  logic [31:0]                         immed,
  input  logic [((LNHART > 0) ? LNHART : 1)-1:0] hart,
  input  logic                                rv32,
  input  logic [NHART*NCOMMIT-1:0]            commit_kill,
  input  logic                                res_stall,
  output logic                                busy,
  output logic                                res_valid,
  output logic [RV-1:0]                       result,
  output logic [LNCOMMIT-1:0]                 res_rd,
  output logic [NHART-1:0]                    res_makes_rd
);

  localparam int HW = (LNHART > 0) ? LNHART : 1;

  logic [3:0]    op;
  logic          inv;
  logic          addw_op;
  logic [RV-1:0] opnd2;
  logic [RV-1:0] b_add;
  logic [RV-1:0] a_add;
  logic [RV-1:0] r1_uw;
  logic [RV-1:0] sum;
  logic [RV-1:0] alu_res;

  logic                         stall;
  logic                         accept;
  logic                         in_kill;
  logic [LAT-1:0]               s_valid;
  logic [LAT-1:0]               s_kill;
  logic [LAT-1:0]               s_mk;
  logic [LAT-1:0][RV-1:0]       s_data;
  logic [LAT-1:0][LNCOMMIT-1:0] s_rd;
  logic [LAT-1:0][HW-1:0]       s_hart;

  // Looks up the kill bit for a {hart, tag} pair; the hart field is ignored on single-hart builds.
  function automatic logic is_killed(input logic [HW-1:0] h, input logic [LNCOMMIT-1:0] t,
                                     input logic [NHART*NCOMMIT-1:0] kv);
    logic [NHART*NCOMMIT-1:0] sh;
    sh = kv >> ((NHART > 1 ? int'(h) : 0) * NCOMMIT + int'(t));
    return sh[0];
  endfunction

  assign op      = {control[5], control[2:0]};
  assign inv     = control[3];
  assign addw_op = (RV == 64) && control[4];
  assign opnd2   = needs_rs2 ? r2 : RV'($signed(immed));
  assign b_add   = inv ? ~opnd2 : opnd2;
  assign r1_uw   = RV'(r1[31:0]);

  always_comb begin
    a_add = r1;
    case (op)
      4'h8: a_add = RV'($signed({pc, 1'b0}));
      4'h9: a_add = (addw_op ? r1_uw : r1) << 1;
      4'ha: a_add = (addw_op ? r1_uw : r1) << 2;
      4'hb: a_add = (addw_op ? r1_uw : r1) << 3;
      4'hc: a_add = r1_uw;
      default: a_add = r1;
    endcase
  end

  assign sum = a_add + b_add + RV'(inv);

`ifdef ALU_ZBB_EN
  logic narrow;
  logic cmp_lt;
  logic cnt_found;
  int   cnt_w;
  int   cnt;

  assign narrow = addw_op | rv32;
  assign cmp_lt = inv ? (r1 < opnd2) : ($signed(r1) < $signed(opnd2));

  // Word-mode counts look only at r1[31:0], so a zero word counts 32 rather than RV.
  always_comb begin
    cnt_w     = narrow ? 32 : RV;
    cnt       = 0;
    cnt_found = 1'b0;
    case (immed[1:0])
      2'b00: for (int i = RV - 1; i >= 0; i--) begin
        if (i < cnt_w && !cnt_found) begin
          if (r1[i]) cnt_found = 1'b1;
          else cnt = cnt + 1;
        end
      end
      2'b01: for (int i = 0; i < RV; i++) begin
        if (i < cnt_w && !cnt_found) begin
          if (r1[i]) cnt_found = 1'b1;
          else cnt = cnt + 1;
        end
      end
      2'b10: for (int i = 0; i < RV; i++) begin
        if (i < cnt_w) cnt = cnt + int'(r1[i]);
      end
      default: cnt = 0;
    endcase
  end
`endif

  always_comb begin
    alu_res = '0;
    case (op)
      4'h0: alu_res = addw_op ? RV'($signed(sum[31:0])) : sum;
      4'h1: alu_res = r1 ^ b_add;
      4'h2: alu_res = r1 & b_add;
      4'h3: alu_res = r1 | b_add;
      4'h4: alu_res = RV'($signed(r1) < $signed(opnd2));
      4'h5: alu_res = RV'(r1 < opnd2);
      4'h8, 4'h9, 4'ha, 4'hb, 4'hc: alu_res = sum;
      4'he: alu_res = RV'(sum[31:0]);
`ifdef ALU_ZBB_EN
      4'h6: alu_res = cmp_lt ? r1 : opnd2;
      4'h7: alu_res = cmp_lt ? opnd2 : r1;
      4'hd: alu_res = RV'(cnt);
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    s_kill = '0;
    for (int i = 0; i < LAT; i++) s_kill[i] = is_killed(s_hart[i], s_rd[i], commit_kill);
  end

  assign in_kill = is_killed(hart, rd, commit_kill);
  assign stall   = res_stall & s_valid[LAT-1];
  assign busy    = stall & s_valid[0];
  assign accept  = enable & ~busy;

  // A stall freezes every stage, but an empty stage 0 may still take a new issue; kill beats stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_valid <= '0;
      s_mk    <= '0;
      s_data  <= '0;
      s_rd    <= '0;
      s_hart  <= '0;
    end else begin
      if (!stall || !s_valid[0]) begin
        s_valid[0] <= accept & ~in_kill;
        s_data[0]  <= alu_res;
        s_rd[0]    <= rd;
        s_hart[0]  <= hart;
        s_mk[0]    <= makes_rd;
      end else if (s_kill[0]) begin
        s_valid[0] <= 1'b0;
      end
      for (int i = 1; i < LAT; i++) begin
        if (!stall) begin
          s_valid[i] <= s_valid[i-1] & ~s_kill[i-1];
          s_data[i]  <= s_data[i-1];
          s_rd[i]    <= s_rd[i-1];
          s_hart[i]  <= s_hart[i-1];
          s_mk[i]    <= s_mk[i-1];
        end else if (s_kill[i]) begin
          s_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign res_valid    = s_valid[LAT-1];
  assign result       = s_data[LAT-1];
  assign res_rd       = s_rd[LAT-1];
  assign res_makes_rd = (s_valid[LAT-1] & s_mk[LAT-1])
                        ? (NHART'(1) << (NHART > 1 ? int'(s_hart[LAT-1]) : 0)) : '0;

  logic unused_bits;
`ifdef ALU_ZBB_EN
  assign unused_bits = ^{control[CNTRL_SIZE-1:6]};
`else
  assign unused_bits = ^{control[CNTRL_SIZE-1:6], rv32};
`endif

  issue_while_busy: assert property (@(posedge clk) disable iff (!reset_n) !(enable && busy));

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (LAT=2, RV=64); ZBB expectations follow ALU_ZBB_EN.
module tb_alu_pipe;
  localparam int RV = 64;
  localparam int VA_SZ = 48;
  localparam int LAT = 2;
`ifdef ALU_ZBB_EN
  localparam bit ZBB = 1'b1;
`else
  localparam bit ZBB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [6:0]       control;
  logic [4:0]       rd;
  logic             makes_rd;
  logic             needs_rs2;
  logic [RV-1:0]    r1;
  logic [RV-1:0]    r2;
  logic [VA_SZ-1:1] pc;
  logic [31:0]      immed;
  logic [0:0]       hart;
  logic             rv32;
  logic [31:0]      commit_kill;
  logic             res_stall;
  logic             busy;
  logic             res_valid;
  logic [RV-1:0]    result;
  logic [4:0]       res_rd;
  logic [0:0]       res_makes_rd;

  int checkCount = 0;
  int failCount = 0;

  typedef struct {
    logic [6:0]  ctl;
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] imm;
    logic        use_imm;
    logic [46:0] pcv;
    logic        mk;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[$];

  alu_pipe #(.RV(RV), .VA_SZ(VA_SZ), .LAT(LAT), .NHART(1), .LNHART(0),
             .NCOMMIT(32), .LNCOMMIT(5), .CNTRL_SIZE(7)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .control(control), .rd(rd),
    .makes_rd(makes_rd), .needs_rs2(needs_rs2), .r1(r1), .r2(r2), .pc(pc), .immed(immed),
    .hart(hart), .rv32(rv32), .commit_kill(commit_kill), .res_stall(res_stall),
    .busy(busy), .res_valid(res_valid), .result(result), .res_rd(res_rd),
    .res_makes_rd(res_makes_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl(input logic [3:0] op, input logic addw, input logic inv);
    return {1'b0, op[3], addw, inv, op[2:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable = 1'b0;
  endtask

  task automatic applyStimulus(input logic [6:0] c, input logic [63:0] a, input logic [63:0] b,
                               input logic [31:0] imm, input logic use_imm, input logic [46:0] pcv,
                               input logic [4:0] tag, input logic mk);
    enable    = 1'b1;
    control   = c;
    r1        = a;
    r2        = b;
    immed     = imm;
    needs_rs2 = ~use_imm;
    pc        = pcv;
    rd        = tag;
    makes_rd  = mk;
  endtask

  task automatic addVec(input logic [6:0] c, input logic [63:0] a, input logic [63:0] b,
                        input logic [31:0] imm, input logic use_imm, input logic [46:0] pcv,
                        input logic [63:0] exp);
    vec_t v;
    v.ctl = c; v.a = a; v.b = b; v.imm = imm; v.use_imm = use_imm; v.pcv = pcv;
    v.mk = (vecs.size() % 3) != 0;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  // Issues every vector back to back and checks each result LAT-1 loop iterations later.
  task automatic runStream();
    int n;
    int k;
    n = vecs.size();
    for (int cyc = 0; cyc < n + LAT - 1; cyc++) begin
      if (cyc < n)
        applyStimulus(vecs[cyc].ctl, vecs[cyc].a, vecs[cyc].b, vecs[cyc].imm, vecs[cyc].use_imm,
                      vecs[cyc].pcv, 5'(cyc), vecs[cyc].mk);
      else
        idle();
      nextCycle();
      if (cyc >= LAT - 1) begin
        k = cyc - (LAT - 1);
        checkOutput($sformatf("vec%0d valid", k), 64'(res_valid), 64'd1);
        checkOutput($sformatf("vec%0d result", k), result, vecs[k].exp);
        checkOutput($sformatf("vec%0d rd", k), 64'(res_rd), 64'(k));
        checkOutput($sformatf("vec%0d makes_rd", k), 64'(res_makes_rd), 64'(vecs[k].mk));
      end
    end
    idle();
    nextCycle();
    checkOutput("stream drained", 64'(res_valid), 64'd0);
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b0; control = '0; rd = '0; makes_rd = 1'b0; needs_rs2 = 1'b1;
    r1 = '0; r2 = '0; pc = '0; immed = '0; hart = '0; rv32 = 1'b0; commit_kill = '0; res_stall = 1'b0;
    #1 reset_n = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("reset res_valid", 64'(res_valid), 64'd0);
    checkOutput("reset result", result, 64'd0);
    checkOutput("reset res_rd", 64'(res_rd), 64'd0);
    checkOutput("reset makes_rd", 64'(res_makes_rd), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    nextCycle();

    $display("[TB] latency check");
    applyStimulus(ctl(4'h0, 0, 0), 64'd5, 64'd7, 32'd0, 1'b0, '0, 5'd3, 1'b1);
    nextCycle();
    idle();
    checkOutput("lat t+1 valid", 64'(res_valid), 64'd0);
    nextCycle();
    checkOutput("lat t+2 valid", 64'(res_valid), 64'd1);
    checkOutput("lat t+2 result", result, 64'd12);
    checkOutput("lat t+2 rd", 64'(res_rd), 64'd3);
    checkOutput("lat t+2 makes_rd", 64'(res_makes_rd), 64'd1);
    nextCycle();
    checkOutput("lat t+3 valid", 64'(res_valid), 64'd0);

    $display("[TB] op stream");
    addVec(ctl(4'h0, 0, 0), 64'd5, 64'd7, 32'd0, 1'b0, '0, 64'd12);
    addVec(ctl(4'h0, 0, 1), 64'd0, 64'd1, 32'd0, 1'b0, '0, 64'hFFFF_FFFF_FFFF_FFFF);
    addVec(ctl(4'h0, 1, 0), 64'h7FFF_FFFF, 64'd1, 32'd0, 1'b0, '0, 64'hFFFF_FFFF_8000_0000);
    addVec(ctl(4'h0, 0, 0), 64'd10, 64'd0, 32'hFFFF_FFFD, 1'b1, '0, 64'd7);
    addVec(ctl(4'h1, 0, 0), 64'hF0, 64'hFF, 32'd0, 1'b0, '0, 64'h0F);
    addVec(ctl(4'h2, 0, 1), 64'hFF, 64'h0F, 32'd0, 1'b0, '0, 64'hF0);
    addVec(ctl(4'h3, 0, 0), 64'hF0, 64'h0F, 32'd0, 1'b0, '0, 64'hFF);
    addVec(ctl(4'h4, 0, 0), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd0, 1'b0, '0, 64'd1);
    addVec(ctl(4'h5, 0, 0), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd0, 1'b0, '0, 64'd0);
    addVec(ctl(4'h8, 0, 0), 64'hDEAD, 64'd4, 32'd0, 1'b0, 47'h800, 64'h1004);
    addVec(ctl(4'ha, 0, 0), 64'd3, 64'd1, 32'd0, 1'b0, '0, 64'd13);
    addVec(ctl(4'hb, 1, 0), 64'hFFFF_FFFF_0000_0002, 64'd1, 32'd0, 1'b0, '0, 64'd17);
    addVec(ctl(4'hc, 0, 0), 64'hFFFF_FFFF_0000_0005, 64'd1, 32'd0, 1'b0, '0, 64'd6);
    addVec(ctl(4'hf, 0, 0), 64'd5, 64'd7, 32'd0, 1'b0, '0, 64'd0);
    addVec(ctl(4'h6, 0, 1), 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b0, '0, ZBB ? 64'd3 : 64'd0);
    addVec(ctl(4'h7, 0, 0), 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 32'd0, 1'b0, '0, ZBB ? 64'd2 : 64'd0);
    addVec(ctl(4'hd, 0, 0), 64'd1, 64'd0, 32'd0, 1'b1, '0, ZBB ? 64'd63 : 64'd0);
    addVec(ctl(4'hd, 1, 0), 64'd1, 64'd0, 32'd0, 1'b1, '0, ZBB ? 64'd31 : 64'd0);
    addVec(ctl(4'hd, 0, 0), 64'd8, 64'd0, 32'd1, 1'b1, '0, ZBB ? 64'd3 : 64'd0);
    addVec(ctl(4'hd, 0, 0), 64'hF0F0, 64'd0, 32'd2, 1'b1, '0, ZBB ? 64'd8 : 64'd0);
    addVec(ctl(4'hd, 0, 0), 64'd0, 64'd0, 32'd0, 1'b1, '0, ZBB ? 64'd64 : 64'd0);
    runStream();

    $display("[TB] stall");
    applyStimulus(ctl(4'h0, 0, 0), 64'd10, 64'd1, 32'd0, 1'b0, '0, 5'd1, 1'b1);
    nextCycle();
    applyStimulus(ctl(4'h1, 0, 0), 64'hF0, 64'h0F, 32'd0, 1'b0, '0, 5'd2, 1'b1);
    nextCycle();
    idle();
    res_stall = 1'b1;
    checkOutput("stall first valid", 64'(res_valid), 64'd1);
    checkOutput("stall first result", result, 64'd11);
    #1;
    checkOutput("stall busy", 64'(busy), 64'd1);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput($sformatf("stall hold%0d result", k), result, 64'd11);
      checkOutput($sformatf("stall hold%0d rd", k), 64'(res_rd), 64'd1);
      checkOutput($sformatf("stall hold%0d busy", k), 64'(busy), 64'd1);
    end
    res_stall = 1'b0;
    #1;
    checkOutput("stall release busy", 64'(busy), 64'd0);
    applyStimulus(ctl(4'h2, 0, 0), 64'hFF, 64'h0F, 32'd0, 1'b0, '0, 5'd3, 1'b1);
    nextCycle();
    checkOutput("stall B result", result, 64'hFF);
    checkOutput("stall B rd", 64'(res_rd), 64'd2);
    applyStimulus(ctl(4'h3, 0, 0), 64'hF0, 64'h0F, 32'd0, 1'b0, '0, 5'd4, 1'b1);
    nextCycle();
    idle();
    checkOutput("stall C result", result, 64'h0F);
    checkOutput("stall C rd", 64'(res_rd), 64'd3);
    nextCycle();
    checkOutput("stall D result", result, 64'hFF);
    checkOutput("stall D rd", 64'(res_rd), 64'd4);
    nextCycle();
    checkOutput("stall drained", 64'(res_valid), 64'd0);

    res_stall = 1'b1;
    applyStimulus(ctl(4'h0, 0, 0), 64'd20, 64'd22, 32'd0, 1'b0, '0, 5'd5, 1'b1);
    nextCycle();
    idle();
    checkOutput("bubble stall busy", 64'(busy), 64'd0);
    nextCycle();
    checkOutput("bubble stall valid", 64'(res_valid), 64'd1);
    checkOutput("bubble stall result", result, 64'd42);
    res_stall = 1'b0;
    nextCycle();
    checkOutput("bubble stall drained", 64'(res_valid), 64'd0);

    $display("[TB] kill");
    applyStimulus(ctl(4'h0, 0, 0), 64'd1, 64'd1, 32'd0, 1'b0, '0, 5'd8, 1'b1);
    nextCycle();
    applyStimulus(ctl(4'h0, 0, 0), 64'd2, 64'd2, 32'd0, 1'b0, '0, 5'd9, 1'b1);
    nextCycle();
    checkOutput("kill rd8 valid", 64'(res_valid), 64'd1);
    checkOutput("kill rd8 rd", 64'(res_rd), 64'd8);
    applyStimulus(ctl(4'h0, 0, 0), 64'd3, 64'd3, 32'd0, 1'b0, '0, 5'd10, 1'b1);
    commit_kill = 32'd1 << 9;
    nextCycle();
    commit_kill = '0;
    idle();
    checkOutput("kill rd9 valid", 64'(res_valid), 64'd0);
    nextCycle();
    checkOutput("kill rd10 valid", 64'(res_valid), 64'd1);
    checkOutput("kill rd10 rd", 64'(res_rd), 64'd10);
    checkOutput("kill rd10 result", result, 64'd6);

    applyStimulus(ctl(4'h0, 0, 0), 64'd1, 64'd1, 32'd0, 1'b0, '0, 5'd12, 1'b1);
    commit_kill = 32'd1 << 12;
    nextCycle();
    commit_kill = '0;
    idle();
    nextCycle();
    checkOutput("kill at issue valid", 64'(res_valid), 64'd0);

    applyStimulus(ctl(4'h0, 0, 0), 64'd4, 64'd4, 32'd0, 1'b0, '0, 5'd20, 1'b1);
    nextCycle();
    idle();
    nextCycle();
    checkOutput("kill stalled valid before", 64'(res_valid), 64'd1);
    res_stall = 1'b1;
    commit_kill = 32'd1 << 20;
    nextCycle();
    checkOutput("kill beats stall", 64'(res_valid), 64'd0);
    res_stall = 1'b0;
    commit_kill = '0;

    $display("[TB] reset mid-flight");
    applyStimulus(ctl(4'h0, 0, 0), 64'd7, 64'd7, 32'd0, 1'b0, '0, 5'd1, 1'b1);
    nextCycle();
    applyStimulus(ctl(4'h0, 0, 0), 64'd8, 64'd8, 32'd0, 1'b0, '0, 5'd2, 1'b1);
    nextCycle();
    idle();
    checkOutput("pre-reset valid", 64'(res_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset valid", 64'(res_valid), 64'd0);
    checkOutput("async reset result", result, 64'd0);
    checkOutput("async reset rd", 64'(res_rd), 64'd0);
    checkOutput("async reset makes_rd", 64'(res_makes_rd), 64'd0);
    nextCycle();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput($sformatf("post-reset valid%0d", k), 64'(res_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
